// File: rtl/ssd1306_pkg.sv
// Shared SSD1306 definitions: command opcodes and the frame writer state set.
package ssd1306_pkg;

  // Page address (OR in page number), lower and upper column nibble commands
  localparam logic [7:0] CMD_SET_PAGE = 8'hB0;
  localparam logic [7:0] CMD_COL_LO   = 8'h00;
  localparam logic [7:0] CMD_COL_HI   = 8'h10;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CMD_PG = 4'd1,
    CMD_LO = 4'd2,
    CMD_HI = 4'd3,
    FETCH  = 4'd4,
    CAPT   = 4'd5,
    SEND   = 4'd6,
    GUARD  = 4'd7,
    WAIT   = 4'd8,
    FIN    = 4'd9
  } fw_state_t;

endpackage

// File: rtl/ssd1306_frame_writer.sv
// Streams one frame from a synchronous-read frame buffer to the SSD1306 via
// shift_reg: per page, page/column address commands (DC=0) then column data
// (DC=1).
//
// Byte handshake with shift_reg: a byte is issued only while byte_ready=1;
// the issuing cycle registers byte_out, oled_dc and a one-cycle byte_start
// together. byte_out/oled_dc then hold until the next byte_start. One GUARD
// cycle ignores byte_ready (shift_reg's ready deassert latency), after which
// WAIT holds until byte_ready=1 again, meaning the byte has fully shifted.
module ssd1306_frame_writer
  import ssd1306_pkg::*;
#(
  parameter int PAGES      = 8,
  parameter int COLS       = 128,
  parameter int COL_OFFSET = 0,
  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk_in,
  input  logic          resetn,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] fb_page,
  output logic [CW-1:0] fb_col,
  output logic          fb_rd,
  input  logic [7:0]    fb_data,
  output logic          byte_start,
  output logic [7:0]    byte_out,
  input  logic          byte_ready,
  output logic          oled_csn,
  output logic          oled_dc,
  output fw_state_t     state_dbg
);

  localparam logic [6:0]    COL_OFF7    = 7'(COL_OFFSET);
  localparam logic [7:0]    CMD_LO_BYTE = CMD_COL_LO | {4'h0, COL_OFF7[3:0]};
  localparam logic [7:0]    CMD_HI_BYTE = CMD_COL_HI | {5'h00, COL_OFF7[6:4]};
  localparam logic [PW-1:0] PAGE_LAST   = PW'(PAGES - 1);
  localparam logic [CW-1:0] COL_LAST    = CW'(COLS - 1);

  fw_state_t     state_q, state_d;
  fw_state_t     last_q, last_d;     // byte-issuing state that led into GUARD
  logic [PW-1:0] page_q, page_d;
  logic [CW-1:0] col_q, col_d;
  logic [7:0]    data_q, data_d;     // frame-buffer byte captured in CAPT

  logic          busy_d, done_d, byte_start_d, oled_csn_d, oled_dc_d;
  logic [7:0]    byte_out_d;

  // Frame-buffer read port and debug view come straight from the registers
  assign fb_rd     = (state_q == FETCH);
  assign fb_page   = page_q;
  assign fb_col    = col_q;
  assign state_dbg = state_q;

  // State, counters and registered outputs; reset abandons any frame
  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      last_q     <= IDLE;
      page_q     <= '0;
      col_q      <= '0;
      data_q     <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_start <= 1'b0;
      byte_out   <= 8'h00;
      oled_csn   <= 1'b1;
      oled_dc    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      page_q     <= page_d;
      col_q      <= col_d;
      data_q     <= data_d;
      busy       <= busy_d;
      done       <= done_d;
      byte_start <= byte_start_d;
      byte_out   <= byte_out_d;
      oled_csn   <= oled_csn_d;
      oled_dc    <= oled_dc_d;
    end
  end

  // Next state and page/column sequencing
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    page_d  = page_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CMD_PG;
          page_d  = '0;
          col_d   = '0;
        end
      end
      CMD_PG, CMD_LO, CMD_HI, SEND: begin
        if (byte_ready) begin
          state_d = GUARD;
          last_d  = state_q;
        end
      end
      GUARD: state_d = WAIT;
      WAIT: begin
        if (byte_ready) begin
          case (last_q)
            CMD_PG:  state_d = CMD_LO;
            CMD_LO:  state_d = CMD_HI;
            CMD_HI:  state_d = FETCH;
            default: begin
              // Data byte completed: step column, then page at end of row
              if (col_q == COL_LAST) begin
                col_d = '0;
                if (page_q == PAGE_LAST) begin
                  state_d = FIN;
                end else begin
                  page_d  = page_q + PW'(1);
                  state_d = CMD_PG;
                end
              end else begin
                col_d   = col_q + CW'(1);
                state_d = FETCH;
              end
            end
          endcase
        end
      end
      FETCH:   state_d = CAPT;
      CAPT:    state_d = SEND;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the captured data byte
  always_comb begin
    busy_d       = busy;
    done_d       = 1'b0;
    byte_start_d = 1'b0;
    byte_out_d   = byte_out;
    oled_csn_d   = oled_csn;
    oled_dc_d    = oled_dc;
    data_d       = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          oled_csn_d = 1'b0;
        end
      end
      CMD_PG: begin
        if (byte_ready) begin
          byte_start_d = 1'b1;
          byte_out_d   = CMD_SET_PAGE | 8'(page_q);
          oled_dc_d    = 1'b0;
        end
      end
      CMD_LO: begin
        if (byte_ready) begin
          byte_start_d = 1'b1;
          byte_out_d   = CMD_LO_BYTE;
          oled_dc_d    = 1'b0;
        end
      end
      CMD_HI: begin
        if (byte_ready) begin
          byte_start_d = 1'b1;
          byte_out_d   = CMD_HI_BYTE;
          oled_dc_d    = 1'b0;
        end
      end
      CAPT: data_d = fb_data;
      SEND: begin
        if (byte_ready) begin
          byte_start_d = 1'b1;
          byte_out_d   = data_q;
          oled_dc_d    = 1'b1;
        end
      end
      FIN: begin
        busy_d     = 1'b0;
        oled_csn_d = 1'b1;
        done_d     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ssd1306_frame_writer.sv
// Bench for ssd1306_frame_writer: a default 8x128 instance and a small 2x4
// instance with COL_OFFSET=0x25, each with a shift_reg model, a random frame
// buffer and a byte-stream reference built from the frame rules.
`timescale 1ns/1ps
module tb_ssd1306_frame_writer;
  import ssd1306_pkg::*;

  typedef struct packed {
    logic [15:0] pos;   // bytes already issued when the read happened
    logic [7:0]  page;
    logic [7:0]  col;
  } rd_t;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic resetn = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  // ---------------- DUT a: defaults ----------------
  logic       start_a, busy_a, done_a, fb_rd_a, byte_start_a, byte_ready_a, csn_a, dc_a;
  logic [2:0] fb_page_a;
  logic [6:0] fb_col_a;
  logic [7:0] fb_data_a, byte_out_a;
  fw_state_t  st_a;

  ssd1306_frame_writer dut_a (
    .clk_in(clk_in), .resetn(resetn), .start(start_a), .busy(busy_a), .done(done_a),
    .fb_page(fb_page_a), .fb_col(fb_col_a), .fb_rd(fb_rd_a), .fb_data(fb_data_a),
    .byte_start(byte_start_a), .byte_out(byte_out_a), .byte_ready(byte_ready_a),
    .oled_csn(csn_a), .oled_dc(dc_a), .state_dbg(st_a)
  );

  // ---------------- DUT b: 2 pages x 4 cols, offset 0x25 ----------------
  logic       start_b, busy_b, done_b, fb_rd_b, byte_start_b, byte_ready_b, csn_b, dc_b;
  logic [0:0] fb_page_b;
  logic [1:0] fb_col_b;
  logic [7:0] fb_data_b, byte_out_b;
  fw_state_t  st_b;

  ssd1306_frame_writer #(.PAGES(2), .COLS(4), .COL_OFFSET(37)) dut_b (
    .clk_in(clk_in), .resetn(resetn), .start(start_b), .busy(busy_b), .done(done_b),
    .fb_page(fb_page_b), .fb_col(fb_col_b), .fb_rd(fb_rd_b), .fb_data(fb_data_b),
    .byte_start(byte_start_b), .byte_out(byte_out_b), .byte_ready(byte_ready_b),
    .oled_csn(csn_b), .oled_dc(dc_b), .state_dbg(st_b)
  );

  // ---------------- models ----------------
  logic [7:0] mem_a [8][128];
  logic [7:0] mem_b [8][128];
  int  busy_len_a = 16, busy_len_b = 3;
  int  busy_cnt_a = 0, busy_cnt_b = 0;
  bit  stall_a = 0, stall_b = 0;
  logic [8:0] got_a[$];
  logic [8:0] got_b[$];
  rd_t rd_a[$];
  rd_t rd_b[$];
  int  dones_a = 0, dones_b = 0, csn_err_a = 0, csn_err_b = 0, dc_err_a = 0, dc_err_b = 0;
  logic dc_prev_a = 1'b0, dc_prev_b = 1'b0, rst_prev = 1'b0;

  // Synchronous-read frame buffers: data valid the cycle after fb_rd, noise otherwise
  always @(posedge clk_in) begin
    fb_data_a <= fb_rd_a ? mem_a[fb_page_a][fb_col_a] : 8'($urandom);
    fb_data_b <= fb_rd_b ? mem_b[fb_page_b][fb_col_b] : 8'($urandom);
  end

  // shift_reg models plus stream monitors, sampled on the falling edge
  always @(negedge clk_in) begin
    if (!resetn) busy_cnt_a = 0;
    else if (byte_start_a) begin
      got_a.push_back({dc_a, byte_out_a});
      busy_cnt_a = busy_len_a;
    end else if (busy_cnt_a > 0) busy_cnt_a--;
    byte_ready_a = (busy_cnt_a == 0) && !stall_a;
    if (fb_rd_a) rd_a.push_back({16'(got_a.size()), 8'(fb_page_a), 8'(fb_col_a)});
    if (done_a) dones_a++;
    if (busy_a && csn_a) csn_err_a++;
    if (resetn && rst_prev && dc_a !== dc_prev_a && !byte_start_a) dc_err_a++;

    if (!resetn) busy_cnt_b = 0;
    else if (byte_start_b) begin
      got_b.push_back({dc_b, byte_out_b});
      busy_cnt_b = busy_len_b;
    end else if (busy_cnt_b > 0) busy_cnt_b--;
    byte_ready_b = (busy_cnt_b == 0) && !stall_b;
    if (fb_rd_b) rd_b.push_back({16'(got_b.size()), 8'(fb_page_b), 8'(fb_col_b)});
    if (done_b) dones_b++;
    if (busy_b && csn_b) csn_err_b++;
    if (resetn && rst_prev && dc_b !== dc_prev_b && !byte_start_b) dc_err_b++;

    dc_prev_a = dc_a;
    dc_prev_b = dc_b;
    rst_prev  = resetn;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected frame stream rebuilt from the frame rules and compared
  task automatic score(input string tag, input int pages, input int cols, input int off,
                       input logic [7:0] mem [8][128], input logic [8:0] got[$], input int gbase,
                       input rd_t rds[$], input int rbase);
    logic [8:0] exp_q[$];
    int k;
    for (int p = 0; p < pages; p++) begin
      exp_q.push_back({1'b0, 8'hB0 + 8'(p)});
      exp_q.push_back({1'b0, 8'(off % 16)});
      exp_q.push_back({1'b0, 8'h10 + 8'((off / 16) % 8)});
      for (int c = 0; c < cols; c++) exp_q.push_back({1'b1, mem[p][c]});
    end
    check_eq({tag, " byte_count"}, got.size() - gbase, pages * (3 + cols));
    check_eq({tag, " rd_count"}, rds.size() - rbase, pages * cols);
    k = gbase;
    while (exp_q.size() > 0 && k < got.size()) begin
      check_eq({tag, " byte"}, 32'(got[k]), 32'(exp_q.pop_front()));
      k++;
    end
    for (int n = 0; n < pages * cols && rbase + n < rds.size(); n++)
      check_eq({tag, " fb_rd"}, 32'(rds[rbase + n]),
               {16'(gbase + (n / cols) * (3 + cols) + 3 + n % cols), 8'(n / cols), 8'(n % cols)});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " busy"}, {busy_a, busy_b}, 2'b00);
    check_eq({tag, " done"}, {done_a, done_b}, 2'b00);
    check_eq({tag, " byte_start"}, {byte_start_a, byte_start_b}, 2'b00);
    check_eq({tag, " byte_out"}, {byte_out_a, byte_out_b}, 16'h0000);
    check_eq({tag, " fb_rd"}, {fb_rd_a, fb_rd_b}, 2'b00);
    check_eq({tag, " fb_addr"}, {fb_page_a, fb_col_a, fb_page_b, fb_col_b}, 13'h0);
    check_eq({tag, " oled_csn"}, {csn_a, csn_b}, 2'b11);
    check_eq({tag, " oled_dc"}, {dc_a, dc_b}, 2'b00);
    check_eq({tag, " state"}, {st_a, st_b}, {IDLE, IDLE});
  endtask

  task automatic fill_mem_a();
    for (int p = 0; p < 8; p++) for (int c = 0; c < 128; c++) mem_a[p][c] = 8'($urandom);
  endtask

  task automatic fill_mem_b();
    for (int p = 0; p < 8; p++) for (int c = 0; c < 128; c++) mem_b[p][c] = 8'($urandom);
  endtask

  // ---------------- stimulus ----------------
  int gbase, rbase, dbase, cbase, cyc, stall_cyc, hold_cnt;
  bit stall_started;
  logic [7:0] hold_byte;
  logic hold_dc;

  initial begin
    start_a = 1'b0;
    start_b = 1'b0;
    fill_mem_a();
    fill_mem_b();
    repeat (3) @(posedge clk_in);
    #2;
    check_reset_outputs("por");
    resetn = 1'b1;
    repeat (2) @(posedge clk_in);

    // Small frame: offset commands, DC split, 14 bytes
    busy_len_b = $urandom_range(1, 6);
    gbase = got_b.size(); rbase = rd_b.size(); dbase = dones_b; cbase = csn_err_b;
    @(posedge clk_in); #2 start_b = 1'b1;
    @(posedge clk_in); #2 start_b = 1'b0;
    check_eq("b busy_after_start", busy_b, 1'b1);
    cyc = 0;
    while (dones_b == dbase && cyc < 3000) begin @(posedge clk_in); #2; cyc++; end
    check_eq("b done_timeout", cyc < 3000, 1'b1);
    repeat (5) @(posedge clk_in);
    #2;
    check_eq("b done_count", dones_b - dbase, 1);
    check_eq("b csn_after", csn_b, 1'b1);
    check_eq("b busy_after", busy_b, 1'b0);
    check_eq("b csn_low_during", csn_err_b - cbase, 0);
    score("b", 2, 4, 37, mem_b, got_b, gbase, rd_b, rbase);

    // Full default frame: 16-cycle shifter, stall before 5th byte, ignored starts
    busy_len_a = 16;
    gbase = got_a.size(); rbase = rd_a.size(); dbase = dones_a; cbase = csn_err_a;
    stall_started = 0;
    cyc = 0;
    while (dones_a == dbase && cyc < 40000) begin
      @(posedge clk_in); #2; cyc++;
      start_a = (cyc == 1 || cyc == 10 || cyc == 50);
      if (!stall_started && got_a.size() - gbase == 4) begin
        stall_a = 1; stall_started = 1; stall_cyc = 0;
        hold_cnt = got_a.size(); hold_byte = byte_out_a; hold_dc = dc_a;
      end else if (stall_a) begin
        stall_cyc++;
        if (stall_cyc == 100) begin
          check_eq("a stall_no_byte_start", got_a.size(), hold_cnt);
          check_eq("a stall_byte_out_held", byte_out_a, hold_byte);
          check_eq("a stall_dc_held", dc_a, hold_dc);
          check_eq("a stall_busy", busy_a, 1'b1);
          stall_a = 0;
        end
      end
    end
    start_a = 1'b0;
    check_eq("a done_timeout", cyc < 40000, 1'b1);
    repeat (5) @(posedge clk_in);
    #2;
    check_eq("a done_count", dones_a - dbase, 1);
    check_eq("a csn_after", csn_a, 1'b1);
    check_eq("a busy_after", busy_a, 1'b0);
    check_eq("a csn_low_during", csn_err_a - cbase, 0);
    score("a", 8, 128, 0, mem_a, got_a, gbase, rd_a, rbase);

    // Reset mid-frame at page 3 / col 40, then a clean restart
    busy_len_a = $urandom_range(1, 4);
    fill_mem_a();
    @(posedge clk_in); #2 start_a = 1'b1;
    @(posedge clk_in); #2 start_a = 1'b0;
    cyc = 0;
    while (!(fb_rd_a && fb_page_a == 3'd3 && fb_col_a == 7'd40) && cyc < 20000) begin
      @(posedge clk_in); #2; cyc++;
    end
    check_eq("a reach_p3c40", cyc < 20000, 1'b1);
    resetn = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    repeat (3) @(posedge clk_in);
    #2 resetn = 1'b1;
    repeat (2) @(posedge clk_in);
    #2;
    check_eq("a idle_after_reset", {busy_a, csn_a}, 2'b01);

    busy_len_a = $urandom_range(1, 6);
    fill_mem_a();
    gbase = got_a.size(); rbase = rd_a.size(); dbase = dones_a; cbase = csn_err_a;
    @(posedge clk_in); #2 start_a = 1'b1;
    @(posedge clk_in); #2 start_a = 1'b0;
    cyc = 0;
    while (dones_a == dbase && cyc < 20000) begin @(posedge clk_in); #2; cyc++; end
    check_eq("a2 done_timeout", cyc < 20000, 1'b1);
    repeat (5) @(posedge clk_in);
    #2;
    check_eq("a2 done_count", dones_a - dbase, 1);
    check_eq("a2 csn_low_during", csn_err_a - cbase, 0);
    score("a2", 8, 128, 0, mem_a, got_a, gbase, rd_a, rbase);

    check_eq("a dc_only_on_byte_start", dc_err_a, 0);
    check_eq("b dc_only_on_byte_start", dc_err_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
